// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and constants for the cache read arbiter.
// Build option ARB_RR_EN (see cache_read_arb) selects round-robin arbitration.
package cache_arb_pkg;

    localparam int LINE_W = 512;
    localparam int OFFS_W = 6;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    // Cached bursts start on a line boundary; uncached reads keep the address.
    function automatic logic [ADDR_W-1:0] burst_addr(
        input logic [ADDR_W-1:0] a,
        input logic              unc
    );
        burst_addr = unc ? a : {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_read_arb_line_buf.sv
// read_line_buffer: collects burst beats into one cache line.
// Cleared on burst start; uncached bursts keep only beat 0, rest stays zero.
module read_line_buffer
    import cache_arb_pkg::*;
#(
    parameter int BEAT_W     = 32,
    parameter int LINE_BEATS = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_beat_vld,
    input  logic [BEAT_W-1:0]            i_beat_data,
    input  logic                         i_uncache,
    output logic [LINE_BEATS*BEAT_W-1:0] o_line
);

    localparam int CNT_W = $clog2(LINE_BEATS);

    logic [CNT_W-1:0]             r_cnt;
    logic [LINE_BEATS*BEAT_W-1:0] r_line;
    logic                         w_wr;

    assign w_wr   = i_beat_vld & (~i_uncache | (r_cnt == '0));
    assign o_line = r_line;

    // Beat counter wraps naturally; each beat lands in its slot of the line.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (i_beat_vld) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wr) begin
                r_line[r_cnt*BEAT_W +: BEAT_W] <= i_beat_data;
            end
        end
    end

endmodule

// File: rtl/cache_read_arb.sv
// cache_read_arb: shares one burst-read channel between ICache and DCache.
// Define ARB_RR_EN for round-robin ties; otherwise DCache wins every tie.
module cache_read_arb
    import cache_arb_pkg::*;
#(
    parameter int BEAT_W     = 32,
    parameter int LINE_BEATS = 16
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              IcReadAble,
    input  logic              IcUncache,
    input  logic [31:0]       IcReadAddr,
    input  logic              IcFlash,
    output logic              IcShankhand,
    output logic              IcReadreq,
    output logic              IcBackAble,
    output logic [LINE_W-1:0] IcBackDate,
    input  logic              DcReadAble,
    input  logic              DcUncache,
    input  logic [31:0]       DcReadAddr,
    output logic              DcShankhand,
    output logic              DcReadreq,
    output logic              DcBackAble,
    output logic [LINE_W-1:0] DcBackDate,
    output logic              MemArValid,
    output logic [31:0]       MemArAddr,
    output logic [3:0]        MemArLen,
    input  logic              MemArReady,
    input  logic              MemRValid,
    input  logic [BEAT_W-1:0] MemRData,
    input  logic              MemRLast,
    output logic              MemRReady
);

    arb_state_e        r_state;
    arb_state_e        w_next;
    owner_e            r_owner;
    owner_e            w_win;
    logic              r_unc;
    logic [31:0]       r_ar_addr;
    logic [3:0]        r_ar_len;
    logic              r_ic_shake;
    logic              r_dc_shake;
    logic              r_drop;
    logic [LINE_W-1:0] r_ic_date;
    logic [LINE_W-1:0] r_dc_date;
    logic [LINE_W-1:0] w_line;
    logic              w_ic_req;
    logic              w_dc_req;
    logic              w_grant;
    logic              w_beat;
    logic              w_win_unc;
    logic [31:0]       w_win_addr;
    logic              w_deliver;

    // A flushing ICache is not a request in that cycle.
    assign w_ic_req = IcReadAble & ~IcFlash;
    assign w_dc_req = DcReadAble;

`ifdef ARB_RR_EN
    owner_e r_rr_ptr;

    // On a tie the side that was not granted last wins.
    always_comb begin
        w_win = w_dc_req ? OWN_DC : OWN_IC;
        if (w_ic_req && w_dc_req) begin
            w_win = (r_rr_ptr == OWN_IC) ? OWN_DC : OWN_IC;
        end
    end

    // Pointer remembers the most recent grant.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_rr_ptr <= OWN_IC;
        end else if (w_grant) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    assign w_win = w_dc_req ? OWN_DC : OWN_IC;
`endif

    assign w_win_unc  = (w_win == OWN_DC) ? DcUncache : IcUncache;
    assign w_win_addr = (w_win == OWN_DC) ? DcReadAddr : IcReadAddr;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus-side handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_beat     = 1'b0;
        MemArValid = 1'b0;
        MemRReady  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ic_req || w_dc_req) begin
                    w_grant = 1'b1;
                    w_next  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                MemArValid = 1'b1;
                if (MemArReady) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                MemRReady = 1'b1;
                w_beat    = MemRValid;
                if (MemRValid && MemRLast) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Capture owner and burst shape when a request wins.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_owner   <= OWN_IC;
            r_unc     <= 1'b0;
            r_ar_addr <= '0;
            r_ar_len  <= '0;
        end else if (w_grant) begin
            r_owner   <= w_win;
            r_unc     <= w_win_unc;
            r_ar_addr <= burst_addr(w_win_addr, w_win_unc);
            r_ar_len  <= w_win_unc ? 4'd0 : 4'(LINE_BEATS - 1);
        end
    end

    // One-cycle accept pulse to the winning cache.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_ic_shake <= 1'b0;
            r_dc_shake <= 1'b0;
        end else begin
            r_ic_shake <= w_grant & (w_win == OWN_IC);
            r_dc_shake <= w_grant & (w_win == OWN_DC);
        end
    end

    // Drop flag: an ICache flush mid-transaction kills its response.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_drop <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_drop <= 1'b0;
        end else if (r_state != ST_IDLE && r_owner == OWN_IC && IcFlash) begin
            r_drop <= 1'b1;
        end
    end

    assign w_deliver = (r_state == ST_RESP) & ~r_drop;

    // Keep each cache's last delivered line on its bus.
    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_ic_date <= '0;
            r_dc_date <= '0;
        end else begin
            if (IcBackAble) begin
                r_ic_date <= w_line;
            end
            if (DcBackAble) begin
                r_dc_date <= w_line;
            end
        end
    end

    read_line_buffer #(
        .BEAT_W     (BEAT_W),
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buf (
        .i_clk       (Clk),
        .i_rst_n     (Rest),
        .i_start     (w_grant),
        .i_beat_vld  (w_beat),
        .i_beat_data (MemRData),
        .i_uncache   (r_unc),
        .o_line      (w_line)
    );

    assign IcShankhand = r_ic_shake;
    assign DcShankhand = r_dc_shake;
    assign IcReadreq   = (r_state != ST_IDLE) && (r_owner == OWN_IC);
    assign DcReadreq   = (r_state != ST_IDLE) && (r_owner == OWN_DC);
    assign IcBackAble  = w_deliver && (r_owner == OWN_IC);
    assign DcBackAble  = w_deliver && (r_owner == OWN_DC);
    assign IcBackDate  = IcBackAble ? w_line : r_ic_date;
    assign DcBackDate  = DcBackAble ? w_line : r_dc_date;
    assign MemArAddr   = r_ar_addr;
    assign MemArLen    = r_ar_len;

endmodule

// File: tb/tb_cache_read_arb.sv
// tb_cache_read_arb: randomized bench with a transaction-level reference model.
// Arbitration expectation follows ARB_RR_EN when the bench is built with it.
module tb_cache_read_arb;
    import cache_arb_pkg::*;

    logic         Clk = 1'b0;
    logic         Rest = 1'b0;
    logic         IcReadAble = 1'b0, IcUncache = 1'b0, IcFlash = 1'b0;
    logic [31:0]  IcReadAddr = '0;
    logic         IcShankhand, IcReadreq, IcBackAble;
    logic [511:0] IcBackDate;
    logic         DcReadAble = 1'b0, DcUncache = 1'b0;
    logic [31:0]  DcReadAddr = '0;
    logic         DcShankhand, DcReadreq, DcBackAble;
    logic [511:0] DcBackDate;
    logic         MemArValid, MemRReady;
    logic [31:0]  MemArAddr;
    logic [3:0]   MemArLen;
    logic         MemArReady = 1'b0, MemRValid = 1'b0, MemRLast = 1'b0;
    logic [31:0]  MemRData = '0;

    always #5 Clk = ~Clk;

    cache_read_arb dut (
        .Clk(Clk), .Rest(Rest),
        .IcReadAble(IcReadAble), .IcUncache(IcUncache),
        .IcReadAddr(IcReadAddr), .IcFlash(IcFlash),
        .IcShankhand(IcShankhand), .IcReadreq(IcReadreq),
        .IcBackAble(IcBackAble), .IcBackDate(IcBackDate),
        .DcReadAble(DcReadAble), .DcUncache(DcUncache),
        .DcReadAddr(DcReadAddr),
        .DcShankhand(DcShankhand), .DcReadreq(DcReadreq),
        .DcBackAble(DcBackAble), .DcBackDate(DcBackDate),
        .MemArValid(MemArValid), .MemArAddr(MemArAddr),
        .MemArLen(MemArLen), .MemArReady(MemArReady),
        .MemRValid(MemRValid), .MemRData(MemRData),
        .MemRLast(MemRLast), .MemRReady(MemRReady)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: who won last, and each cache's last delivered line.
    bit           last_dc = 1'b0;
    logic [511:0] ic_last = '0;
    logic [511:0] dc_last = '0;
    int           ar_force = -1;
    bit           seq_beats = 1'b0;
    logic [31:0]  beat_base = '0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {IcShankhand, IcReadreq, IcBackAble, DcShankhand,
            DcReadreq, DcBackAble, MemArValid, MemRReady}, '0);
        chk({tag, "_ar"}, {MemArAddr, MemArLen}, '0);
        chk({tag, "_icd"}, IcBackDate, '0);
        chk({tag, "_dcd"}, DcBackDate, '0);
    endtask

    task automatic serve_one(input bit win_dc, input logic [31:0] addr,
                             input bit unc, input bit flush);
        logic [31:0]  exp_addr;
        logic [3:0]   exp_len;
        logic [511:0] exp_line;
        logic [31:0]  d;
        bit           got_shake;
        bit           dropped;
        int           nb;
        int           dly;
        exp_addr  = unc ? addr : (addr & 32'hFFFF_FFC0);
        exp_len   = unc ? 4'd0 : 4'd15;
        nb        = unc ? 1 : 16;
        got_shake = 1'b0;
        for (int t = 0; t < 20 && !got_shake; t++) begin
            tick();
            got_shake = IcShankhand | DcShankhand;
        end
        chk("grant_seen", got_shake, 1);
        if (!got_shake) return;
        chk("shake_who", {IcShankhand, DcShankhand}, win_dc ? 2'b01 : 2'b10);
        if (win_dc) DcReadAble = 1'b0;
        else IcReadAble = 1'b0;
        chk("readreq", {IcReadreq, DcReadreq}, win_dc ? 2'b01 : 2'b10);
        chk("ar_valid", MemArValid, 1);
        chk("ar_addr", MemArAddr, exp_addr);
        chk("ar_len", MemArLen, exp_len);
        dly = (ar_force >= 0) ? ar_force : int'($urandom_range(0, 3));
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("ar_hold", {MemArValid, MemArAddr, MemArLen, MemRReady,
                IcShankhand, DcShankhand}, {1'b1, exp_addr, exp_len, 3'b000});
        end
        MemArReady = 1'b1;
        tick();
        MemArReady = 1'b0;
        chk("data_entry", {MemArValid, MemRReady, IcShankhand, DcShankhand},
            4'b0100);
        exp_line = '0;
        dropped  = 1'b0;
        for (int k = 0; k < nb; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            d = seq_beats ? beat_base + 32'(k) : $urandom;
            MemRValid = 1'b1;
            MemRData  = d;
            MemRLast  = (k == nb - 1);
            if (flush && k == nb / 2) begin
                IcFlash = 1'b1;
                if (!win_dc) dropped = 1'b1;
            end
            if (k == 0 || !unc) exp_line[k*32 +: 32] = d;
            tick();
            MemRValid = 1'b0;
            MemRLast  = 1'b0;
            IcFlash   = 1'b0;
        end
        if (!dropped) begin
            if (win_dc) dc_last = exp_line;
            else ic_last = exp_line;
        end
        chk("resp_able", {IcBackAble, DcBackAble},
            dropped ? 2'b00 : (win_dc ? 2'b01 : 2'b10));
        chk("resp_ic_data", IcBackDate, ic_last);
        chk("resp_dc_data", DcBackDate, dc_last);
        chk("resp_bus", {MemArValid, MemRReady}, 0);
        tick();
        chk("idle_out", {IcBackAble, DcBackAble, IcReadreq, DcReadreq,
            IcShankhand, DcShankhand, MemArValid, MemRReady}, 0);
        chk("hold_ic", IcBackDate, ic_last);
        chk("hold_dc", DcBackDate, dc_last);
    endtask

    task automatic round(input bit ic_on, input bit dc_on,
                         input logic [31:0] ia, input bit iu,
                         input logic [31:0] da, input bit du, input bit fl);
        bit pic;
        bit pdc;
        bit w;
        pic = ic_on;
        pdc = dc_on;
        IcReadAble = ic_on;
        IcUncache  = iu;
        IcReadAddr = ia;
        DcReadAble = dc_on;
        DcUncache  = du;
        DcReadAddr = da;
        while (pic || pdc) begin
            if (pic && pdc) begin
`ifdef ARB_RR_EN
                w = ~last_dc;
`else
                w = 1'b1;
`endif
            end else begin
                w = pdc;
            end
            last_dc = w;
            serve_one(w, w ? da : ia, w ? du : iu, fl);
            if (w) pdc = 1'b0;
            else pic = 1'b0;
        end
    endtask

    task automatic reset_mid_data();
        bit got;
        IcReadAble = 1'b1;
        IcUncache  = 1'b0;
        IcReadAddr = $urandom;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            got = IcShankhand;
        end
        chk("rst_grant", got, 1);
        IcReadAble = 1'b0;
        MemArReady = 1'b1;
        tick();
        MemArReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            MemRValid = 1'b1;
            MemRData  = $urandom;
            tick();
        end
        MemRValid = 1'b0;
        Rest = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        Rest    = 1'b1;
        last_dc = 1'b0;
        ic_last = '0;
        dc_last = '0;
    endtask

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");
        Rest = 1'b1;
        tick();

        seq_beats = 1'b1;
        beat_base = 32'h0;
        round(1, 0, 32'h1C00_0044, 0, 32'h0, 0, 0);
        beat_base = 32'hDEAD_BEEF;
        round(0, 1, 32'h0, 0, 32'hBFD0_0004, 1, 0);
        seq_beats = 1'b0;

        round(1, 1, $urandom, 0, $urandom, 0, 0);
        round(1, 1, $urandom, 1, $urandom, 0, 0);

        round(1, 0, $urandom, 0, 32'h0, 0, 1);
        round(0, 1, 32'h0, 0, $urandom, 0, 0);

        ar_force = 5;
        round(1, 0, $urandom, 0, 32'h0, 0, 0);
        ar_force = -1;

        reset_mid_data();
        round(1, 0, $urandom, 0, 32'h0, 0, 0);

        for (int r = 0; r < 30; r++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            round(sel[0], sel[1], $urandom, 1'($urandom_range(0, 1)),
                  $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
